// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM protocol types.
// Used by the memory responder and its wait-state counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ramop_t;

  localparam int unsigned WBYTES = 4;
  localparam int unsigned WOFF   = 2;
  localparam int unsigned CW     = 4;

endpackage

// File: rtl/ram_wait_ctr.sv
// Wait-state counter and request latch for the RAM responder.
// Flags new requests and reports when the held request may access.
module ram_wait_ctr
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  ramop_t        op_i,
  input  logic [AW-1:0] addr_i,
  input  word_t         store_i,
  output logic          is_new_o,
  output logic          done_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] LATW = CW'(LAT);

  logic [CW-1:0] count_q, count_d;
  ramop_t        op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  word_t         store_q, store_d;
  logic          busy_q, busy_d;
  logic          match;

  assign match = (op_i == op_q) && (addr_i == addr_q)
              && (store_i == store_q);

  // Only a request that was BUSY last cycle can continue counting.
  assign is_new_o = !busy_q || !match;
  assign done_o   = (count_q == LATW);
  assign count_o  = count_q;

  always_comb begin
    count_d = '0;
    op_d    = op_q;
    addr_d  = addr_q;
    store_d = store_q;
    busy_d  = 1'b0;
    if (req_i) begin
      if (is_new_o) begin
        op_d    = op_i;
        addr_d  = addr_i;
        store_d = store_i;
        if (LATW != '0) begin
          count_d = CW'(1);
          busy_d  = 1'b1;
        end
      end else if (count_q < LATW) begin
        count_d = count_q + CW'(1);
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      store_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Word-addressed RAM responder with programmable wait states.
// Decodes errors, muxes ramstate/ramload and holds the array.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          ramREN,
  input  logic          ramWEN,
  input  logic [AW-1:0] ramaddr,
  input  word_t         ramstore,
  output word_t         ramload,
  output ramstate_t     ramstate
);

  localparam int unsigned IW = $clog2(DEPTH);

  word_t           mem_q [DEPTH];
  logic [AW-3:0]   widx;
  logic [IW-1:0]   idx;
  logic            present, err, req;
  logic            is_new, done, access, wr_en;
  logic [CW-1:0]   count;
  logic            unused_count;
  ramop_t          op;

  assign widx    = ramaddr[AW-1:WOFF];
  assign idx     = widx[IW-1:0];
  assign present = ramREN ^ ramWEN;
  assign err     = (ramREN & ramWEN)
                 | (present & (ramaddr[WOFF-1:0] != '0))
                 | (present & (widx >= (AW-2)'(DEPTH)));
  assign req     = present & ~err;
  assign op      = ramWEN ? OP_WR : OP_RD;
  assign access  = req & (is_new ? (LAT == 0) : done);
  assign unused_count = ^count;

  ram_wait_ctr #(
    .LAT (LAT),
    .AW  (AW)
  ) u_ctr (
    .clk      (CLK),
    .rst_n    (nRST),
    .req_i    (req),
    .op_i     (op),
    .addr_i   (ramaddr),
    .store_i  (ramstore),
    .is_new_o (is_new),
    .done_o   (done),
    .count_o  (count)
  );

  // Reset forces FREE so a held request is not reported mid-reset.
  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    wr_en    = 1'b0;
    if (!nRST) begin
      ramstate = FREE;
    end else if (err) begin
      ramstate = ERROR;
    end else if (present) begin
      if (access) begin
        ramstate = ACCESS;
        if (op == OP_RD) ramload = mem_q[idx];
        else             wr_en   = 1'b1;
      end else begin
        ramstate = BUSY;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder (LAT=2 and LAT=0 builds).
// Random held/aborted transactions are checked against a word-array model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int L = 2;
  localparam int D = 256;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0;
  word_t       store = '0;
  word_t       ld2, ld0;
  ramstate_t   st2, st0;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(L), .DEPTH(D), .AW(32)) dut2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(store), .ramload(ld2), .ramstate(st2)
  );

  ram_responder #(.LAT(0), .DEPTH(D), .AW(32)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(store), .ramload(ld0), .ramstate(st0)
  );

  task automatic drive(input logic r, input logic w,
                       input logic [31:0] a, input word_t d);
    ren = r; wen = w; addr = a; store = d;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0); #1;
    tests++;
    if (st2 !== FREE || ld2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_lat2: got st=%0d ld=%h want st=0 ld=0", st2, ld2);
    end
    tests++;
    if (st0 !== FREE || ld0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_lat0: got st=%0d ld=%h want st=0 ld=0", st0, ld0);
    end
    @(negedge CLK); nRST = 1'b1; #1;
    tests++;
    if (st2 !== FREE || ld2 !== 32'h0) begin
      fails++;
      $display("FAIL after_reset: got st=%0d ld=%h want st=0 ld=0", st2, ld2);
    end
    for (int k = 0; k <= L; k++) begin
      @(negedge CLK); drive(1, 0, 32'h0, 32'h0); #1;
      tests++;
      if (st2 !== ((k < L) ? BUSY : ACCESS) || ld2 !== 32'h0) begin
        fails++;
        $display("FAIL reset_read0 c%0d: got st=%0d ld=%h want st=%0d ld=0",
                 k, st2, ld2, (k < L) ? 1 : 2);
      end
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k <= L; k++) begin
      @(negedge CLK); drive(0, 1, 32'h10, 32'hDEADBEEF); #1;
      tests++;
      if (st2 !== ((k < L) ? BUSY : ACCESS) || ld2 !== 32'h0) begin
        fails++;
        $display("FAIL wr10 c%0d: got st=%0d ld=%h", k, st2, ld2);
      end
    end
    for (int k = 0; k <= L; k++) begin
      @(negedge CLK); drive(1, 0, 32'h10, 32'h0); #1;
      tests++;
      if (st2 !== ((k < L) ? BUSY : ACCESS)
          || ld2 !== ((k < L) ? 32'h0 : 32'hDEADBEEF)) begin
        fails++;
        $display("FAIL rd10 c%0d: got st=%0d ld=%h", k, st2, ld2);
      end
    end
  endtask

  task automatic test_addr_change();
    logic [31:0] wa [2];
    word_t       wd [2];
    wa[0] = 32'h20; wd[0] = 32'hAAAA1111;
    wa[1] = 32'h24; wd[1] = 32'hBBBB2222;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k <= L; k++) begin
        @(negedge CLK); drive(0, 1, wa[j], wd[j]);
      end
    for (int k = 0; k <= L + 1; k++) begin
      @(negedge CLK);
      drive(1, 0, (k == 0) ? 32'h20 : 32'h24, 32'h0); #1;
      tests++;
      if (st2 !== ((k <= L) ? BUSY : ACCESS)
          || ld2 !== ((k <= L) ? 32'h0 : 32'hBBBB2222)) begin
        fails++;
        $display("FAIL addr_abort c%0d: got st=%0d ld=%h", k, st2, ld2);
      end
    end
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_store_change();
    for (int k = 0; k <= L + 1; k++) begin
      @(negedge CLK);
      drive(0, 1, 32'h30, (k == 0) ? 32'h1234 : 32'h5678); #1;
      tests++;
      if (st2 !== ((k <= L) ? BUSY : ACCESS)) begin
        fails++;
        $display("FAIL store_abort c%0d: got st=%0d", k, st2);
      end
    end
    for (int k = 0; k <= L; k++) begin
      @(negedge CLK); drive(1, 0, 32'h30, 32'h0); #1;
    end
    tests++;
    if (st2 !== ACCESS || ld2 !== 32'h5678) begin
      fails++;
      $display("FAIL store_readback: got st=%0d ld=%h want st=2 ld=5678",
               st2, ld2);
    end
  endtask

  task automatic test_error();
    logic [3:0]  er, ew;
    logic [31:0] ea [4];
    er = 4'b0111; ew = 4'b1001;
    ea[0] = 32'h40; ea[1] = 32'h42; ea[2] = 32'(4 * D); ea[3] = 32'(4 * D);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK); drive(er[j], ew[j], ea[j], 32'hFFFF0000 | j); #1;
      tests++;
      if (st2 !== ERROR || ld2 !== 32'h0) begin
        fails++;
        $display("FAIL error%0d: got st=%0d ld=%h want st=3 ld=0",
                 j, st2, ld2);
      end
    end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k <= L; k++) begin
        @(negedge CLK); drive(1, 0, (j == 0) ? 32'h40 : 32'h0, 32'h0); #1;
        tests++;
        if (st2 !== ((k < L) ? BUSY : ACCESS) || ld2 !== 32'h0) begin
          fails++;
          $display("FAIL err_readback%0d c%0d: got st=%0d ld=%h",
                   j, k, st2, ld2);
        end
      end
  endtask

  task automatic test_lat0();
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); drive(1, 0, 32'h8, 32'h0); #1;
      tests++;
      if (st0 !== ACCESS || ld0 !== 32'h0) begin
        fails++;
        $display("FAIL lat0_rd c%0d: got st=%0d ld=%h", k, st0, ld0);
      end
    end
    @(negedge CLK); drive(0, 1, 32'h8, 32'hCAFEF00D); #1;
    tests++;
    if (st0 !== ACCESS) begin
      fails++;
      $display("FAIL lat0_wr: got st=%0d want 2", st0);
    end
    @(negedge CLK); drive(1, 0, 32'h8, 32'h0); #1;
    tests++;
    if (st0 !== ACCESS || ld0 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL lat0_readback: got st=%0d ld=%h want ld=cafef00d",
               st0, ld0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0);
    for (int k = 0; k < L; k++) begin
      @(negedge CLK); drive(0, 1, 32'h50, 32'h77);
    end
    #2 nRST = 1'b0; #1;
    tests++;
    if (st2 !== FREE || ld2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: got st=%0d ld=%h want st=0", st2, ld2);
    end
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0);
    @(negedge CLK); nRST = 1'b1;
    for (int k = 0; k <= L; k++) begin
      @(negedge CLK); drive(1, 0, 32'h50, 32'h0); #1;
    end
    tests++;
    if (st2 !== ACCESS || ld2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_readback: got st=%0d ld=%h want st=2 ld=0",
               st2, ld2);
    end
  endtask

  task automatic test_random();
    word_t       model [D];
    logic        w;
    logic [31:0] a;
    word_t       d;
    int          c;
    bit          abort;
    for (int i = 0; i < D; i++) model[i] = '0;
    @(negedge CLK); drive(0, 0, 32'h0, 32'h0); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge CLK); drive(0, 0, 32'h0, 32'h0); #1;
        tests++;
        if (st2 !== FREE || ld2 !== 32'h0) begin
          fails++;
          $display("FAIL rnd_idle t%0d: got st=%0d ld=%h", t, st2, ld2);
        end
      end
      w     = 1'($urandom_range(0, 1));
      a     = 32'($urandom_range(0, 15)) << 2;
      d     = $urandom;
      abort = ($urandom_range(0, 3) == 0);
      c     = 0;
      forever begin
        if (abort && c == 1) begin
          a = 32'($urandom_range(16, D - 1)) << 2;
          c = 0;
          abort = 1'b0;
        end
        @(negedge CLK); drive(!w, w, a, d); #1;
        tests++;
        if (st2 !== ((c < L) ? BUSY : ACCESS)
            || ld2 !== ((c == L && !w) ? model[a[9:2]] : 32'h0)) begin
          fails++;
          $display("FAIL rnd t%0d c%0d w%0d a=%h: got st=%0d ld=%h want ld=%h",
                   t, c, w, a, st2, ld2,
                   (c == L && !w) ? model[a[9:2]] : 32'h0);
        end
        if (c == L) break;
        c++;
      end
      if (w) model[a[9:2]] = d;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_change();
    test_store_change();
    test_error();
    test_lat0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
